// File: rtl/cache_bus_pkg.sv
// CPU-side cache bus encodings and widths shared by the scratchpad slice.
package cache_bus_pkg;

  localparam int A_W    = 15;
  localparam int D_W    = 16;
  localparam int C_W    = 3;
  localparam int OFF_W  = 4;
  localparam int ADDR_W = 19;

  typedef enum logic [C_W-1:0] {
    CMD_NOP     = 3'd0,
    CMD_READ8   = 3'd1,
    CMD_READ16  = 3'd2,
    CMD_READ32  = 3'd3,
    CMD_INVAL   = 3'd4,
    CMD_WRITE8  = 3'd5,
    CMD_WRITE16 = 3'd6,
    CMD_WRITE32 = 3'd7
  } cmd_e;

  localparam logic [C_W-1:0] C_RESPONSE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ2,
    ST_WAIT,
    ST_RESP1,
    ST_RESP2
  } sp_state_e;

  function automatic logic is_read(input cmd_e c);
    return (c == CMD_READ8) || (c == CMD_READ16) || (c == CMD_READ32);
  endfunction

  function automatic logic [3:0] wr_be(input cmd_e c);
    logic [3:0] be;
    be = 4'b0000;
    case (c)
      CMD_WRITE8:  be = 4'b0001;
      CMD_WRITE16: be = 4'b0011;
      CMD_WRITE32: be = 4'b1111;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sp_byte_store.sv
// Byte-addressed scratchpad array: wrapping 4-byte read, byte-enabled write,
// synchronous clear of every byte.
module sp_byte_store #(
  parameter int DEPTH_BYTES = 256,
  parameter int IW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [IW-1:0] i_widx,
  input  logic [31:0]   i_wdata,
  input  logic [IW-1:0] i_ridx,
  output logic [31:0]   o_rdata
);

  logic [7:0] r_mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH_BYTES; i++)
        r_mem[i] <= 8'h00;
    end else if (i_we) begin
      for (int i = 0; i < 4; i++)
        if (i_be[i])
          r_mem[IW'(i_widx + IW'(i))] <= i_wdata[8*i +: 8];
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < 4; i++)
      o_rdata[8*i +: 8] = r_mem[IW'(i_ridx + IW'(i))];
  end

endmodule

// File: rtl/c1_scratchpad.sv
// Fixed-latency uncached scratchpad answering CPU commands on the shared
// C1/D1 bus; the only tristate drivers sit here behind r_drv.
module c1_scratchpad
  import cache_bus_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int LATENCY     = 6
) (
  input  logic           clk,
  input  logic           RESET,
  input  logic [A_W-1:0] A1,
  inout  wire  [C_W-1:0] C1,
  inout  wire  [D_W-1:0] D1
);

  localparam int IW = $clog2(DEPTH_BYTES);

  sp_state_e        r_state, w_nxt;
  cmd_e             r_cmd;
  logic [A_W-1:0]   r_tag;
  logic [OFF_W-1:0] r_off;
  logic [D_W-1:0]   r_dlo;
  logic [4:0]       r_cnt;
  logic             r_drv;
  logic [C_W-1:0]   r_c_out;
  logic [D_W-1:0]   r_d_out;

  logic             w_req;
  logic             w_we;
  logic [IW-1:0]    w_widx;
  logic [IW-1:0]    w_ridx;
  logic [31:0]      w_rd;
  logic [D_W-1:0]   w_d_nxt;
  logic [ADDR_W-1:0] w_waddr;
  logic [ADDR_W-1:0] w_raddr;

  // Unknown or floating C1 never matches an item, so it reads as NOP.
  always_comb begin
    w_req = 1'b0;
    case (C1)
      3'd1, 3'd2, 3'd3, 3'd4,
      3'd5, 3'd6, 3'd7: w_req = 1'b1;
      default:          w_req = 1'b0;
    endcase
  end

  assign w_waddr = {r_tag, A1[OFF_W-1:0]};
  assign w_raddr = {r_tag, r_off};
  assign w_widx  = IW'(w_waddr % ADDR_W'(DEPTH_BYTES));
  assign w_ridx  = IW'(w_raddr % ADDR_W'(DEPTH_BYTES));
  assign w_we    = (r_state == ST_REQ2) && !RESET;

  sp_byte_store #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_store (
    .clk    (clk),
    .i_clr  (RESET),
    .i_we   (w_we),
    .i_be   (wr_be(r_cmd)),
    .i_widx (w_widx),
    .i_wdata({D1, r_dlo}),
    .i_ridx (w_ridx),
    .o_rdata(w_rd)
  );

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_req) w_nxt = ST_REQ2;
      ST_REQ2:  w_nxt = ST_WAIT;
      ST_WAIT:  if (r_cnt <= 5'd1) w_nxt = ST_RESP1;
      ST_RESP1: w_nxt = (r_cmd == CMD_READ32) ? ST_RESP2 : ST_IDLE;
      ST_RESP2: w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_d_nxt = '0;
    if (w_nxt == ST_RESP1 && is_read(r_cmd)) begin
      if (r_cmd == CMD_READ8) w_d_nxt = {8'h00, w_rd[7:0]};
      else                    w_d_nxt = w_rd[15:0];
    end else if (w_nxt == ST_RESP2) begin
      w_d_nxt = w_rd[31:16];
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_cmd   <= CMD_NOP;
      r_tag   <= '0;
      r_off   <= '0;
      r_dlo   <= '0;
      r_cnt   <= '0;
      r_drv   <= 1'b0;
      r_c_out <= '0;
      r_d_out <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_IDLE && w_req) begin
        r_cmd <= cmd_e'(C1);
        r_tag <= A1;
        r_dlo <= D1;
      end
      if (r_state == ST_REQ2) begin
        r_off <= A1[OFF_W-1:0];
        r_cnt <= 5'(LATENCY);
      end else if (r_state == ST_WAIT && r_cnt != 5'd0) begin
        r_cnt <= r_cnt - 5'd1;
      end
      r_drv   <= (w_nxt == ST_RESP1) || (w_nxt == ST_RESP2);
      r_c_out <= C_RESPONSE;
      r_d_out <= w_d_nxt;
    end
  end

  assign C1 = r_drv ? r_c_out : 'z;
  assign D1 = r_drv ? r_d_out : 'z;

endmodule

// File: tb/tb_c1_scratchpad.sv
// Directed bench for c1_scratchpad acting as the CPU end of the bus.
module tb_c1_scratchpad;

  localparam int DEPTH = 256;
  localparam int L     = 6;

  logic        clk = 1'b0;
  logic        RESET;
  logic [14:0] A1;
  wire  [2:0]  C1;
  wire  [15:0] D1;

  logic        cpu_c_en, cpu_d_en;
  logic [2:0]  cpu_c;
  logic [15:0] cpu_d;

  int n_assert = 0;
  int n_fail   = 0;

  assign C1 = cpu_c_en ? cpu_c : 'z;
  assign D1 = cpu_d_en ? cpu_d : 'z;

  // Weak pulls make a released bus read as C1=0, D1=FFFF.
  for (genvar g = 0; g < 3; g++) begin : g_pc
    pulldown (C1[g]);
  end
  for (genvar g = 0; g < 16; g++) begin : g_pd
    pullup (D1[g]);
  end

  c1_scratchpad #(
    .DEPTH_BYTES(DEPTH),
    .LATENCY    (L)
  ) dut (
    .clk  (clk),
    .RESET(RESET),
    .A1   (A1),
    .C1   (C1),
    .D1   (D1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_c_en || cpu_d_en) begin
      n_assert++;
      assert (!(cpu_c_en && C1 !== cpu_c) && !(cpu_d_en && D1 !== cpu_d))
      else begin
        n_fail++;
        $error("FAIL contention: observed C1=%h D1=%h expected C1=%h D1=%h",
               C1, D1, cpu_c, cpu_d);
      end
    end
  end

  task automatic xact(input string tag, input logic [2:0] cmd,
                      input logic [14:0] ts, input logic [3:0] off,
                      input logic [31:0] wd, input logic [15:0] e0,
                      input logic [15:0] e1, input bit two);
    logic quiet;
    cpu_c = cmd; cpu_c_en = 1'b1;
    A1 = ts; cpu_d = wd[15:0]; cpu_d_en = 1'b1;
    @(posedge clk); #1;
    cpu_c_en = 1'b0;
    A1 = {11'd0, off}; cpu_d = wd[31:16];
    @(posedge clk); #1;
    cpu_d_en = 1'b0;
    quiet = 1'b1;
    repeat (L) begin
      @(negedge clk);
      if (C1 !== 3'd0 || D1 !== 16'hFFFF) quiet = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, " quiet"}, {31'd0, quiet}, 32'd1);
    @(negedge clk);
    chk({tag, " c1"}, {29'd0, C1}, 32'd7);
    chk({tag, " d0"}, {16'd0, D1}, {16'd0, e0});
    if (two) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " c1b"}, {29'd0, C1}, 32'd7);
      chk({tag, " d1"}, {16'd0, D1}, {16'd0, e1});
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " rel"}, {13'd0, C1, D1}, {13'd0, 3'd0, 16'hFFFF});
    @(posedge clk); #1;
    cpu_c = 3'd0; cpu_c_en = 1'b1;
  endtask

  initial begin : main
    logic quiet;
    RESET = 1'b1; A1 = '0;
    cpu_c = 3'd0; cpu_c_en = 1'b1;
    cpu_d = '0;   cpu_d_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 RESET = 1'b0;
    @(negedge clk);
    chk("reset rel", {13'd0, C1, D1}, {13'd0, 3'd0, 16'hFFFF});
    @(posedge clk); #1;

    xact("rd32 cold",   3'd3, 15'h0001, 4'h4, 32'h0,        16'h0000, 16'h0000, 1);
    xact("wr32",        3'd7, 15'h0000, 4'h0, 32'hDEADBEEF, 16'h0000, 16'h0000, 0);
    xact("rd16 a0",     3'd2, 15'h0000, 4'h0, 32'h0,        16'hBEEF, 16'h0000, 0);
    xact("rd8 a3",      3'd1, 15'h0000, 4'h3, 32'h0,        16'h00DE, 16'h0000, 0);
    xact("inval",       3'd4, 15'h0000, 4'h0, 32'h0,        16'h0000, 16'h0000, 0);
    xact("rd32 a0",     3'd3, 15'h0000, 4'h0, 32'h0,        16'hBEEF, 16'hDEAD, 1);
    xact("wr16 wrap",   3'd6, 15'h000F, 4'hF, 32'h00001234, 16'h0000, 16'h0000, 0);
    xact("rd8 top",     3'd1, 15'h000F, 4'hF, 32'h0,        16'h0034, 16'h0000, 0);
    xact("rd8 a0",      3'd1, 15'h0000, 4'h0, 32'h0,        16'h0012, 16'h0000, 0);
    xact("rd8 alias",   3'd1, 15'h0100, 4'h0, 32'h0,        16'h0012, 16'h0000, 0);
    xact("rd16 wrap",   3'd2, 15'h000F, 4'hF, 32'h0,        16'h1234, 16'h0000, 0);
    xact("wr8 a1",      3'd5, 15'h0000, 4'h1, 32'h00007755, 16'h0000, 16'h0000, 0);
    xact("rd32 merge",  3'd3, 15'h0000, 4'h0, 32'h0,        16'h5512, 16'hDEAD, 1);

    cpu_c = 3'd5; cpu_c_en = 1'b1;
    A1 = 15'h0001; cpu_d = 16'h0055; cpu_d_en = 1'b1;
    @(posedge clk); #1;
    cpu_c_en = 1'b0; A1 = '0; cpu_d = 16'h0000;
    @(posedge clk); #1;
    cpu_d_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    quiet = 1'b1;
    repeat (L + 3) begin
      @(negedge clk);
      if (C1 !== 3'd0 || D1 !== 16'hFFFF) quiet = 1'b0;
      @(posedge clk); #1;
    end
    chk("abort quiet", {31'd0, quiet}, 32'd1);
    cpu_c = 3'd0; cpu_c_en = 1'b1;
    @(posedge clk); #1;

    xact("rd8 aborted", 3'd1, 15'h0001, 4'h0, 32'h0, 16'h0000, 16'h0000, 0);
    xact("rd32 clear",  3'd3, 15'h0000, 4'h0, 32'h0, 16'h0000, 16'h0000, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
